mem_arbiter: RTL

Two-requester arbiter that shares the single memory port between the core control FSM (port 0) and a secondary master such as a debug loader or DMA (port 1). It sits between the requesters and the memory. It registers the winning request, drives the memory read/write strobes until `mem_resp` or a timeout, and returns a one-cycle response with registered read data to the winner.

---
 rtl/mem_arbiter_if.sv | 55 +++++
 rtl/mem_arbiter.sv | 129 ++++++++++++
 2 files changed

// File: rtl/mem_arbiter_if.sv
// Requester, memory and status bundle for mem_arbiter.
// slave: arbiter side; master: requesters plus memory model.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();
  logic              req0_read;
  logic              req0_write;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_wdata;
  logic [DATA_W-1:0] req0_rdata;
  logic              req0_resp;
  logic              req0_err;
  logic              req1_read;
  logic              req1_write;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_wdata;
  logic [DATA_W-1:0] req1_rdata;
  logic              req1_resp;
  logic              req1_err;
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_resp;
  logic              busy;
  logic              grant;

  modport slave (
    input  req0_read, req0_write,
    input  req0_addr, req0_wdata,
    output req0_rdata, req0_resp, req0_err,
    input  req1_read, req1_write,
    input  req1_addr, req1_wdata,
    output req1_rdata, req1_resp, req1_err,
    output mem_read, mem_write,
    output mem_addr, mem_wdata,
    input  mem_rdata, mem_resp,
    output busy, grant
  );

  modport master (
    output req0_read, req0_write,
    output req0_addr, req0_wdata,
    input  req0_rdata, req0_resp, req0_err,
    output req1_read, req1_write,
    output req1_addr, req1_wdata,
    input  req1_rdata, req1_resp, req1_err,
    input  mem_read, mem_write,
    input  mem_addr, mem_wdata,
    output mem_rdata, mem_resp,
    input  busy, grant
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter with timeout abort.
// MEM_ARB_RR_EN selects round-robin; default is fixed priority.
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input logic          clk,
  input logic          rst_n,
  mem_arbiter_if.slave bus
);
  localparam int CW =
    (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_MAX =
    CW'(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST =
    CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam bit TO_EN = (TIMEOUT != 0);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_e;

  state_e            state_q, state_d;
  logic              grant_q, grant_d;
  logic              wr_q, wr_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [CW-1:0]     cnt_q, cnt_d;

  logic req0, req1, win;
  logic done0, done1;

  assign req0 = bus.req0_read | bus.req0_write;
  assign req1 = bus.req1_read | bus.req1_write;

`ifdef MEM_ARB_RR_EN
  assign win = (req0 & req1) ? ~grant_q : req1;
`else
  assign win = ~req0;
`endif

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    wr_d    = wr_q;
    err_d   = err_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (req0 | req1) begin
          state_d = BUSY;
          grant_d = win;
          cnt_d   = '0;
          if (win) begin
            wr_d    = bus.req1_write;
            addr_d  = bus.req1_addr;
            wdata_d = bus.req1_wdata;
          end else begin
            wr_d    = bus.req0_write;
            addr_d  = bus.req0_addr;
            wdata_d = bus.req0_wdata;
          end
        end
      end
      BUSY: begin
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
        // response wins over a same-cycle timeout
        if (bus.mem_resp) begin
          state_d = DONE;
          err_d   = 1'b0;
          rdata_d = wr_q ? '0 : bus.mem_rdata;
        end else if (TO_EN && cnt_q == CNT_LAST) begin
          state_d = DONE;
          err_d   = 1'b1;
          rdata_d = '0;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= 1'b1;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      wr_q    <= wr_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
    end
  end

  assign done0 = (state_q == DONE) & ~grant_q;
  assign done1 = (state_q == DONE) & grant_q;

  assign bus.mem_read  = (state_q == BUSY) & ~wr_q;
  assign bus.mem_write = (state_q == BUSY) & wr_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.grant     = grant_q;

  assign bus.req0_resp  = done0;
  assign bus.req0_err   = done0 & err_q;
  assign bus.req0_rdata = done0 ? rdata_q : '0;
  assign bus.req1_resp  = done1;
  assign bus.req1_err   = done1 & err_q;
  assign bus.req1_rdata = done1 ? rdata_q : '0;
endmodule
